// File: rtl/weight_mask_encoder.sv
// weight_mask_encoder
//   Converts a dense vector of 16 x 4-bit two's-complement weights into the
//   4-of-8 structured-sparse format: per 8-lane half, a keep bitmap with
//   exactly 4 bits set plus the 4 kept weights packed in ascending lane order.
//   Two-stage valid/ready pipeline (S1: lane flags/magnitudes/weights,
//   S2: encoded mask/data), 1 vector per cycle, 2-edge latency.
//
// Build option:
//   MAG_PRUNE_EN  defined   -> over-full halves keep the 4 largest-|w| lanes
//                              (ties to the lower lane index)
//                 undefined -> over-full halves keep the 4 lowest nonzero lanes
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake, in_weight lane n at [4n+3:4n]
//   out_valid/out_ready   output handshake
//   out_mask[15:0]        keep bitmap, half 0 in [7:0], half 1 in [15:8]
//   out_wdata[31:0]       kept weights, half 0 in [15:0], half 1 in [31:16]
//   prune_cnt, pad_cnt    saturating counts of accepted over-/under-full halves
module weight_mask_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_weight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_mask,
    output logic [31:0]      out_wdata,
    output logic [CNT_W-1:0] prune_cnt,
    output logic [CNT_W-1:0] pad_cnt
);
    localparam int NUM_LANES = 16;

    typedef struct packed {
        logic [7:0]  mask;
        logic [15:0] data;
    } half_enc_t;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // Lane i survives when fewer than 4 lanes outrank it (larger key, or equal
    // key at a lower index). Exactly 4 lanes always survive. With key = nonzero
    // flag this keeps the lowest nonzero lanes and pads with the lowest zero
    // lanes; with key = magnitude it keeps the largest lanes, and since zero
    // lanes have the smallest key the padding rule falls out the same way.
    function automatic half_enc_t encode_half(input logic [7:0][3:0] key,
                                              input logic [7:0][3:0] w);
        half_enc_t r;
        logic [3:0] rank;
        int         slot;
        r    = '0;
        slot = 0;
        for (int i = 0; i < 8; i++) begin
            rank = '0;
            for (int j = 0; j < 8; j++)
                if ((key[j] > key[i]) || ((key[j] == key[i]) && (j < i)))
                    rank = rank + 4'd1;
            if (rank < 4'd4) begin
                r.mask[i] = 1'b1;
                r.data[4*slot +: 4] = w[i];
                slot = slot + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // ---------------- handshake ----------------
    logic s1_vld_q, s2_vld_q;
    logic s1_adv, s2_adv, accept;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    // ---------------- S0 -> S1 lane analysis ----------------
    logic [NUM_LANES-1:0][3:0] lane_w;
    logic [NUM_LANES-1:0]      nz_d;
    assign lane_w = in_weight;

`ifdef MAG_PRUNE_EN
    logic [NUM_LANES-1:0][3:0] mag_d;
`endif

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign nz_d[n] = |lane_w[n];
`ifdef MAG_PRUNE_EN
        // 4-bit unsigned result, so |-8| = 8 without overflow
        assign mag_d[n] = lane_w[n][3] ? (4'd0 - lane_w[n]) : lane_w[n];
`endif
    end

    logic [1:0] prune_inc, pad_inc;
    always_comb begin
        prune_inc = '0;
        pad_inc   = '0;
        for (int h = 0; h < 2; h++) begin
            if (popcnt8(nz_d[h*8 +: 8]) > 4'd4) prune_inc = prune_inc + 2'd1;
            if (popcnt8(nz_d[h*8 +: 8]) < 4'd4) pad_inc   = pad_inc + 2'd1;
        end
    end

    logic [CNT_W-1:0] prune_q, pad_q, prune_d, pad_d;
    assign prune_d = sat_add(prune_q, prune_inc);
    assign pad_d   = sat_add(pad_q, pad_inc);

    // ---------------- S1 registers ----------------
    logic [1:0][7:0][3:0] s1_w_q;
    logic [1:0][7:0][3:0] key;
`ifdef MAG_PRUNE_EN
    // magnitude is zero exactly when the lane is zero, so it doubles as the
    // nonzero flag in this build
    logic [1:0][7:0][3:0] s1_mag_q;
    always_ff @(posedge clk)
        if (rst_n && accept) s1_mag_q <= mag_d;
    assign key = s1_mag_q;
`else
    logic [NUM_LANES-1:0] s1_nz_q;
    always_ff @(posedge clk)
        if (rst_n && accept) s1_nz_q <= nz_d;
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_key
        assign key[n/8][n%8] = {3'b000, s1_nz_q[n]};
    end
`endif

    always_ff @(posedge clk)
        if (rst_n && accept) s1_w_q <= in_weight;

    // ---------------- S1 -> S2 selection ----------------
    half_enc_t [1:0] enc;
    for (genvar h = 0; h < 2; h++) begin : g_half
        assign enc[h] = encode_half(key[h], s1_w_q[h]);
    end

    logic [15:0] mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    // invalid slots load zeros so the outputs read 0 whenever out_valid is low
    assign mask_d  = s1_vld_q ? {enc[1].mask, enc[0].mask} : '0;
    assign wdata_d = s1_vld_q ? {enc[1].data, enc[0].data} : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            mask_q   <= '0;
            wdata_q  <= '0;
            prune_q  <= '0;
            pad_q    <= '0;
        end else begin
            if (s1_adv) s1_vld_q <= in_valid;
            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
                mask_q   <= mask_d;
                wdata_q  <= wdata_d;
            end
            if (accept) begin
                prune_q <= prune_d;
                pad_q   <= pad_d;
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign out_mask  = mask_q;
    assign out_wdata = wdata_q;
    assign prune_cnt = prune_q;
    assign pad_cnt   = pad_q;

endmodule

// File: tb/tb_weight_mask_encoder.sv
// Directed testbench for weight_mask_encoder (CNT_W = 4 so saturation is reachable).
// Expected values follow the MAG_PRUNE_EN build selection when that macro is set.
module tb_weight_mask_encoder;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_weight = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [15:0]      out_mask;
    logic [31:0]      out_wdata;
    logic [CNT_W-1:0] prune_cnt;
    logic [CNT_W-1:0] pad_cnt;

    weight_mask_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_wdata(out_wdata),
        .prune_cnt(prune_cnt), .pad_cnt(pad_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_prune = 0;
    int exp_pad   = 0;

    typedef struct {
        logic [63:0] w;
        logic [15:0] mask;
        logic [31:0] wdata;
        int          prune_inc;
        int          pad_inc;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n     = 1'b1;
        exp_prune = 0;
        exp_pad   = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        in_valid  = 1'b1;
        in_weight = v.w;
        out_ready = 1'b1;
        tick();                       // accept edge
        in_valid  = 1'b0;
        exp_prune = sat15(exp_prune + v.prune_inc);
        exp_pad   = sat15(exp_pad + v.pad_inc);
        tick();                       // S2 edge
        check($sformatf("v%0d_valid", idx), out_valid, 1);
        check($sformatf("v%0d_mask", idx), out_mask, v.mask);
        check($sformatf("v%0d_wdata", idx), out_wdata, v.wdata);
        check($sformatf("v%0d_prune", idx), prune_cnt, exp_prune);
        check($sformatf("v%0d_pad", idx), pad_cnt, exp_pad);
        tick();                       // drained
        check($sformatf("v%0d_idle", idx), {out_valid, out_mask, out_wdata}, 0);
    endtask

    task automatic push(input logic [63:0] w, input string name);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_weight = w;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: in_ready stuck at 0, required 1", name);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    // 10 distinct vectors, each half0 lanes 0-3 = k+1, rest zero
    function automatic logic [15:0] fnib(input int k);
        logic [3:0] n;
        n = 4'(k + 1);
        return {n, n, n, n};
    endfunction

    task automatic flow_test();
        int       sent, recv;
        bit       saw_stall, hold_prev;
        logic [48:0] prev;
        sent = 0; recv = 0; saw_stall = 0; hold_prev = 0; prev = '0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            in_valid  = (sent < 10);
            in_weight = {48'h0, fnib(sent)};
            out_ready = !(cyc >= 3 && cyc <= 7);
            @(negedge clk);
            if (hold_prev)
                check($sformatf("flow_hold_c%0d", cyc), {out_valid, out_mask, out_wdata}, prev);
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("flow_out%0d", recv), {out_mask, out_wdata},
                      {16'h0F0F, 16'h0000, fnib(recv)});
                recv++;
            end
            hold_prev = out_valid && !out_ready;
            prev      = {out_valid, out_mask, out_wdata};
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("flow_sent", sent, 10);
        check("flow_recv", recv, 10);
        check("flow_stall_seen", saw_stall, 1);
    endtask

    initial begin
        tbl[0] = '{64'h0000_0000_3000_A0B1, 16'h0F8B, 32'h0000_3AB1, 0, 1};
`ifdef MAG_PRUNE_EN
        tbl[1] = '{64'h0000_0000_8765_4321, 16'h0FF0, 32'h0000_8765, 1, 1};
        tbl[2] = '{64'h0C0D_0E0F_7001_1187, 16'h5587, 32'hCDEF_7187, 1, 0};
        tbl[5] = '{64'h08D3_E2F1_0090_0000, 16'h7427, 32'h8D32_9000, 1, 1};
`else
        tbl[1] = '{64'h0000_0000_8765_4321, 16'h0F0F, 32'h0000_4321, 1, 1};
        tbl[2] = '{64'h0C0D_0E0F_7001_1187, 16'h550F, 32'hCDEF_1187, 1, 0};
        tbl[5] = '{64'h08D3_E2F1_0090_0000, 16'h0F27, 32'hE2F1_9000, 1, 1};
`endif
        tbl[3] = '{64'h0000_0000_0000_0000, 16'h0F0F, 32'h0000_0000, 0, 2};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'h0F0F, 32'hFFFF_FFFF, 2, 0};

        // reset state
        do_reset();
        check("reset_state", {in_ready, out_valid, out_mask, out_wdata, prune_cnt, pad_cnt},
              {1'b1, 1'b0, 16'h0, 32'h0, 4'h0, 4'h0});

        // table vectors
        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // backpressure / ordering
        do_reset();
        flow_test();

        // mid-stream reset with two vectors in flight
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_weight = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        in_weight = 64'h0000_0000_0000_1111;
        tick();
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_prune", prune_cnt, 2);
        rst_n     = 1'b0;
        in_weight = 64'hFFFF_FFFF_FFFF_FFFF;   // must not be taken on the reset edge
        tick();
        check("rst_post", {out_valid, in_ready, prune_cnt, pad_cnt}, {1'b0, 1'b1, 4'h0, 4'h0});
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("rst_no_stale%0d", c), {out_valid, out_mask, out_wdata, prune_cnt}, 0);
        end

        // counter saturation
        do_reset();
        for (int k = 0; k < 13; k++) push(64'h0000_FFFF_FFFF_FFFF, "sat_a");
        check("sat_13", prune_cnt, 13);
        push(64'hFFFF_FFFF_FFFF_FFFF, "sat_b");
        check("sat_15", prune_cnt, 15);
        for (int k = 0; k < 3; k++) push(64'h0000_FFFF_FFFF_FFFF, "sat_c");
        check("sat_hold", prune_cnt, 15);
        check("sat_pad", pad_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/weight_mask_encoder.md
WEIGHT_MASK_ENCODER -- requirements
Module: weight_mask_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating status counters.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  dense weight vector present.
REQ-005 SHALL have port in_ready  output  1  encoder accepts in_weight this cycle.
REQ-006 SHALL have port in_weight  input  64  16 x 4-bit two's-complement weights, lane n at [4n+3:4n].
REQ-007 SHALL have port out_valid  output  1  encoded word present.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the encoded word.
REQ-009 SHALL have port out_mask  output  16  keep bitmap; bit n set means lane n kept.
REQ-010 SHALL have port out_wdata  output  32  8 x 4-bit packed kept weights; half 0 (lanes 0-7) in [15:0], half 1 (lanes 8-15) in [31:16], ascending lane order, lowest lane in the lowest nibble.
REQ-011 SHALL have port prune_cnt  output  CNT_W  number of accepted halves with more than 4 nonzero weights.
REQ-012 SHALL have port pad_cnt  output  CNT_W  number of accepted halves with fewer than 4 nonzero weights.

Function
REQ-013 SHALL encode each 8-lane half independently, so each half of out_mask has exactly 4 set bits; this is the 4-of-8 format the 14-group selector consumes.
REQ-014 SHALL, for a half with exactly 4 nonzero lanes, set the mask bits of those lanes and pack their values.
REQ-015 SHALL, for a half with fewer than 4 nonzero lanes, keep all nonzero lanes and pad with the lowest-index zero lanes up to 4 kept lanes; padded nibbles are 0.
REQ-016 SHALL, for a half with more than 4 nonzero lanes, keep 4 lanes chosen per REQ-027/REQ-028.
REQ-017 SHALL use a two-stage pipeline: S1 registers the per-half nonzero flags, magnitudes and weights; S2 registers out_mask, out_wdata and out_valid.
REQ-018 SHALL set latency to 2 clk edges from the in_valid&&in_ready edge to out_valid when out_ready is held high, with throughput of 1 vector per cycle.
REQ-019 SHALL advance S2 when !out_valid || out_ready, and advance S1 when S1 is empty or S2 advances.
REQ-020 SHALL drive in_ready = !s1_valid || s2_advance, combinationally, with no dependence on in_valid.
REQ-021 SHALL hold out_mask, out_wdata and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL drop no data and duplicate no data under any pattern of in_valid and out_ready, including simultaneous accept and emit on a full pipeline.
REQ-023 SHALL increment prune_cnt and pad_cnt once per qualifying half on the input accept edge (0, 1 or 2 per vector), saturating at all-ones.
REQ-024 SHALL drive out_mask and out_wdata to 0 whenever out_valid is low.

Reset
REQ-025 SHALL, when rst_n is low at a clk edge, clear the S1/S2 valids, out_mask, out_wdata, prune_cnt and pad_cnt; in_ready is then 1 and out_valid is 0.
REQ-026 SHALL discard in-flight vectors on a reset asserted mid-stream, and accept no input on a reset edge.

Configuration
REQ-027 SHALL, with macro MAG_PRUNE_EN defined, resolve over-full halves by keeping the 4 largest-magnitude lanes, where |-8| = 8 and ties go to the lower lane index; this selection is computed in S1->S2.
REQ-028 SHALL, without MAG_PRUNE_EN, resolve over-full halves by keeping the 4 lowest-index nonzero lanes; latency and interface are identical in both builds.

Verification
REQ-029 SHALL cover: in_weight=64'h0000_0000_3000_A0B1 (half0 lanes 0,1,3 nonzero: 1,B,A; lane 7 = 3), out_ready=1 -> 2 cycles later out_mask=16'h0F8B, out_wdata=32'h0000_3AB1, pad_cnt=1 (half1 all zero pads lanes 8-11).
REQ-030 SHALL cover: half0 lanes 0-7 = 1,2,3,4,5,6,7,8 (in_weight[31:0]=32'h8765_4321) -> without macro: mask[7:0]=8'h0F, wdata[15:0]=16'h4321; with macro: mask[7:0]=8'hF0, wdata[15:0]=16'h8765; prune_cnt increments by 1.
REQ-031 SHALL cover: half0 lanes = 7,-8(8),1,1,1,0,0,7 with MAG_PRUNE_EN -> lanes 0,1,7 kept plus lane 2 (tie broken to lowest index); mask[7:0]=8'h87.
REQ-032 SHALL cover: 10 back-to-back vectors with out_ready held low for cycles 3-7 -> in_ready falls after 2 vectors are buffered, outputs hold stable, and all 10 emerge in order with no loss.
REQ-033 SHALL cover: rst_n pulsed low for 1 cycle with 2 vectors in flight -> out_valid=0 on the next cycle, counters=0, and no stale vector appears afterward.
REQ-034 SHALL cover: prune_cnt preloaded near saturation (CNT_W=4, 15 events) followed by 3 more over-full halves -> prune_cnt stays at 4'hF.
